// File: rtl/output_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// output_conditioner_pkg
// Shared definitions for the output conditioner: the controller state encoding
// and the default hold-counter width and hold time.
// ----------------------------------------------------------------------------
package output_conditioner_pkg;

    localparam int DEFAULT_COUNTER_WIDTH = 5;
    localparam int DEFAULT_HOLD_TIME     = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        RETURN = 2'd2
    } state_t;

endpackage

// File: rtl/output_conditioner_hold_timer.sv
// ----------------------------------------------------------------------------
// hold_timer
// Up-counter that measures how long the conditioned pin has held its level.
// It counts from 0 up to LIMIT-1 and then stays there until it is cleared.
//
// Ports
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset, clears the count
//   clear    : synchronous clear to 0; takes priority over enable
//   enable   : advance the count by one this cycle
//   terminal : count has reached LIMIT-1
// ----------------------------------------------------------------------------
module hold_timer #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 14
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // Increment is gated by terminal so the count saturates at LIMIT-1
    // instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/output_conditioner.sv
// ----------------------------------------------------------------------------
// output_conditioner
// Drives a glitch-free output pin that, once changed, holds each level for at
// least HOLD_TIME cycles. Accepts level requests (move pin to req_level) and
// pulse requests (invert pin for HOLD_TIME cycles, then restore it).
//
// Ports
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   req_valid    : a request is presented
//   req_level    : target level for a level request
//   req_pulse    : request is a pulse; req_level is ignored
//   req_ready    : block can accept a request this cycle (decoded from state)
//   pin          : registered output level
//   positiveedge : one-cycle flag in the first cycle pin reads 1 after 0
//   negativeedge : one-cycle flag in the first cycle pin reads 0 after 1
//   done         : one-cycle flag when an accepted request has completed
//   dbg_state    : current controller state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE and does not depend on
// req_valid; holding req_valid high while req_ready is 0 has no effect and the
// request is taken on the first IDLE cycle.
// ----------------------------------------------------------------------------
module output_conditioner
    import output_conditioner_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int HOLD_TIME     = DEFAULT_HOLD_TIME
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req_valid,
    input  logic   req_level,
    input  logic   req_pulse,
    output logic   req_ready,
    output logic   pin,
    output logic   positiveedge,
    output logic   negativeedge,
    output logic   done,
    output state_t dbg_state
);

    if (HOLD_TIME < 1 || HOLD_TIME > (2 ** COUNTER_WIDTH) - 1) begin : g_bad_hold_time
        $error("output_conditioner: HOLD_TIME out of range for COUNTER_WIDTH");
    end

    state_t state, state_next;
    logic   pin_next;
    logic   pending, pending_next;
    logic   done_next;
    logic   timer_clear, timer_enable, timer_terminal;

    hold_timer #(
        .WIDTH (COUNTER_WIDTH),
        .LIMIT (HOLD_TIME)
    ) u_hold_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .terminal (timer_terminal)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_next   = state;
        pin_next     = pin;
        pending_next = pending;
        done_next    = 1'b0;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        case (state)
            IDLE: begin
                // Keep the timer at 0 so every hold starts from a clean count.
                timer_clear = 1'b1;
                if (req_valid) begin
                    if (req_pulse) begin
                        pin_next     = ~pin;
                        pending_next = 1'b1;
                        state_next   = HOLD;
                    end else if (req_level != pin) begin
                        pin_next   = req_level;
                        state_next = HOLD;
                    end else begin
                        // Already at the requested level: complete at once.
                        done_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                timer_enable = 1'b1;
                if (timer_terminal) begin
                    if (pending) begin
                        // Second half of a pulse: restore pin and time it again.
                        pin_next     = ~pin;
                        pending_next = 1'b0;
                        timer_clear  = 1'b1;
                        state_next   = RETURN;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            RETURN: begin
                timer_enable = 1'b1;
                if (timer_terminal) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    // Edge flags are computed from the registered pin and its next value, so
    // they rise in the same cycle as the new pin level and a reset-forced fall
    // of pin never produces a negativeedge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pin          <= 1'b0;
            pending      <= 1'b0;
            done         <= 1'b0;
            positiveedge <= 1'b0;
            negativeedge <= 1'b0;
        end else begin
            state        <= state_next;
            pin          <= pin_next;
            pending      <= pending_next;
            done         <= done_next;
            positiveedge <= pin_next & ~pin;
            negativeedge <= ~pin_next & pin;
        end
    end

    assign req_ready = (state == IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_output_conditioner.sv
// ----------------------------------------------------------------------------
// tb_output_conditioner
// Directed bench for output_conditioner (HOLD_TIME=14) plus a second instance
// built with HOLD_TIME=1 for the single-cycle pulse case.
// ----------------------------------------------------------------------------
module tb_output_conditioner;
  import output_conditioner_pkg::*;

  localparam int H = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic   req_valid = 1'b0;
  logic   req_level = 1'b0;
  logic   req_pulse = 1'b0;
  logic   req_ready, pin, positiveedge, negativeedge, done;
  state_t dut_state;

  output_conditioner dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_level    (req_level),
    .req_pulse    (req_pulse),
    .req_ready    (req_ready),
    .pin          (pin),
    .positiveedge (positiveedge),
    .negativeedge (negativeedge),
    .done         (done),
    .dbg_state    (dut_state)
  );

  // ---------------- HOLD_TIME=1 DUT ----------------
  logic   s_valid = 1'b0;
  logic   s_pulse = 1'b0;
  logic   s_ready, s_pin, s_pe, s_ne, s_done;
  state_t s_state;

  output_conditioner #(
    .COUNTER_WIDTH (2),
    .HOLD_TIME     (1)
  ) dut_short (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (s_valid),
    .req_level    (1'b0),
    .req_pulse    (s_pulse),
    .req_ready    (s_ready),
    .pin          (s_pin),
    .positiveedge (s_pe),
    .negativeedge (s_ne),
    .done         (s_done),
    .dbg_state    (s_state)
  );

  // ---------------- checking ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- pin monitor (samples on falling edge) ----------------
  int   pos_cnt = 0, neg_cnt = 0, done_cnt = 0;
  int   edge_err = 0, dwell_viol = 0, run_len = 0;
  logic last_pin = 1'b0;
  bit   run_valid = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      last_pin  = pin;
      run_valid = 1'b0;
      run_len   = 0;
    end else begin
      if (positiveedge) pos_cnt++;
      if (negativeedge) neg_cnt++;
      if (done) done_cnt++;
      if (positiveedge && negativeedge) edge_err++;
      if (positiveedge !== (pin && !last_pin)) edge_err++;
      if (negativeedge !== (!pin && last_pin)) edge_err++;
      if (pin != last_pin) begin
        if (run_valid && run_len < H) dwell_viol++;
        run_valid = 1'b1;
        run_len   = 1;
      end else begin
        run_len++;
      end
      last_pin = pin;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, then waits (bounded) for done.
  // lat  : cycles from the acceptance edge to the cycle done is visible
  // busy : sampled cycles with req_ready low before done
  // hi   : sampled cycles with pin high before done
  task automatic run_req(input logic lvl, input logic pls,
                         output logic pin_a, output logic pe_a, output logic ne_a,
                         output int lat, output int busy, output int hi);
    req_valid = 1'b1;
    req_level = lvl;
    req_pulse = pls;
    tick();
    req_valid = 1'b0;
    req_pulse = 1'b0;
    pin_a = pin;
    pe_a  = positiveedge;
    ne_a  = negativeedge;
    lat = 0;
    busy = 0;
    hi = 0;
    while (!done && lat < 100) begin
      if (!req_ready) busy++;
      if (pin) hi++;
      tick();
      lat++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic pa, pe, ne;
    int   lat, busy, hi;
    int   p_pos, p_neg, d0, n0, n, cyc, w;
    int   chg[4];
    logic prev;

    // reset values while reset_n is low
    #3;
    check("reset_pin", int'(pin), 0);
    check("reset_ready", int'(req_ready), 1);
    check("reset_pe", int'(positiveedge), 0);
    check("reset_ne", int'(negativeedge), 0);
    check("reset_done", int'(done), 0);
    check("reset_state", int'(dut_state), int'(IDLE));
    tick();
    tick();
    reset_n = 1'b1;

    // idle 20 cycles
    repeat (20) tick();
    check("idle_pin", int'(pin), 0);
    check("idle_ready", int'(req_ready), 1);
    check("idle_edges", pos_cnt + neg_cnt, 0);
    check("idle_done", done_cnt, 0);

    // level request to 1
    run_req(1'b1, 1'b0, pa, pe, ne, lat, busy, hi);
    check("lvl1_pin", int'(pa), 1);
    check("lvl1_pe", int'(pe), 1);
    check("lvl1_latency", lat, H);
    check("lvl1_busy", busy, H);
    check("lvl1_ready_at_done", int'(req_ready), 1);

    // level request equal to current pin
    run_req(1'b1, 1'b0, pa, pe, ne, lat, busy, hi);
    check("eq_pin", int'(pa), 1);
    check("eq_pe", int'(pe), 0);
    check("eq_ne", int'(ne), 0);
    check("eq_latency", lat, 0);
    check("eq_ready", int'(req_ready), 1);

    // level request back to 0
    run_req(1'b0, 1'b0, pa, pe, ne, lat, busy, hi);
    check("lvl0_pin", int'(pa), 0);
    check("lvl0_ne", int'(ne), 1);
    check("lvl0_latency", lat, H);

    // pulse request from pin=0
    p_pos = pos_cnt;
    p_neg = neg_cnt;
    run_req(1'b0, 1'b1, pa, pe, ne, lat, busy, hi);
    check("pulse_pin", int'(pa), 1);
    check("pulse_pe", int'(pe), 1);
    check("pulse_high_cycles", hi, H);
    check("pulse_latency", lat, 2 * H);
    check("pulse_busy", busy, 2 * H);
    tick();
    check("pulse_rises", pos_cnt - p_pos, 1);
    check("pulse_falls", neg_cnt - p_neg, 1);
    check("pulse_pin_end", int'(pin), 0);

    // HOLD_TIME=1 pulse is exactly one cycle wide
    s_valid = 1'b1;
    s_pulse = 1'b1;
    tick();
    s_valid = 1'b0;
    s_pulse = 1'b0;
    check("short_pin_high", int'(s_pin), 1);
    check("short_pe", int'(s_pe), 1);
    tick();
    check("short_pin_low", int'(s_pin), 0);
    check("short_ne", int'(s_ne), 1);
    check("short_done_early", int'(s_done), 0);
    tick();
    check("short_done", int'(s_done), 1);

    // req_valid held high with alternating level
    req_pulse = 1'b0;
    req_valid = 1'b1;
    req_level = ~pin;
    prev = pin;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (pin != prev) begin
        chg[n] = cyc;
        n++;
        prev = pin;
        req_level = ~pin;
      end
    end
    req_valid = 1'b0;
    check("alt_changes", n, 4);
    if (n == 4) begin
      check("alt_gap1", chg[1] - chg[0], H + 1);
      check("alt_gap2", chg[2] - chg[1], H + 1);
      check("alt_gap3", chg[3] - chg[2], H + 1);
    end
    w = 0;
    while (!done && w < 100) begin
      tick();
      w++;
    end
    check("alt_final_done", int'(done), 1);

    // reset in the middle of HOLD with pin=1
    req_valid = 1'b1;
    req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    check("rst_pre_pin", int'(pin), 1);
    check("rst_pre_state", int'(dut_state), int'(HOLD));
    d0 = done_cnt;
    n0 = neg_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_pin", int'(pin), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_ne", int'(negativeedge), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dut_state), int'(IDLE));
    tick();
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_negedge", neg_cnt - n0, 0);
    check("rst_pin_after", int'(pin), 0);

    // operation resumes after reset
    run_req(1'b1, 1'b0, pa, pe, ne, lat, busy, hi);
    check("resume_pin", int'(pa), 1);
    check("resume_pe", int'(pe), 1);
    check("resume_latency", lat, H);

    // whole-run pin properties
    tick();
    check("edge_consistency", edge_err, 0);
    check("dwell_min", dwell_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/output_conditioner.md
OUTPUT_CONDITIONER -- requirements
Module: output_conditioner

Interface
REQ-001 The block SHALL have parameter COUNTER_WIDTH, default 5, setting the width of the hold counter.
REQ-002 The block SHALL have parameter HOLD_TIME, default 14, giving the minimum number of cycles pin stays at each driven level.
REQ-003 HOLD_TIME SHALL satisfy 1 <= HOLD_TIME <= 2^COUNTER_WIDTH-1.
REQ-004 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1 bit: a request is presented.
REQ-007 Port req_level, input, 1 bit: target pin level for a level request.
REQ-008 Port req_pulse, input, 1 bit: when 1, the request inverts pin for HOLD_TIME cycles and then restores it; req_level is ignored.
REQ-009 Port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-010 Port pin, output, 1 bit: registered, glitch-free output level.
REQ-011 Port positiveedge, output, 1 bit: 1-cycle pulse in the same cycle pin first reads 1 after being 0.
REQ-012 Port negativeedge, output, 1 bit: 1-cycle pulse in the same cycle pin first reads 0 after being 1.
REQ-013 Port done, output, 1 bit: 1-cycle pulse when an accepted request completes.

Function
REQ-014 A request SHALL be accepted only in a cycle where req_valid and req_ready are both 1.
REQ-015 The block SHALL have the states IDLE, HOLD and RETURN; req_ready SHALL be 1 in IDLE and 0 otherwise.
REQ-016 Level request in IDLE with req_level equal to pin SHALL leave pin unchanged, pulse done on the next cycle, and stay in IDLE.
REQ-017 Level request in IDLE with req_level different from pin SHALL drive pin to req_level on the next cycle, clear the counter, and enter HOLD.
REQ-018 Pulse request in IDLE SHALL drive pin to ~pin on the next cycle, record pulse_pending, clear the counter, and enter HOLD.
REQ-019 In HOLD and RETURN the counter SHALL increment by 1 each cycle, wrap-free, and never exceed HOLD_TIME-1.
REQ-020 HOLD with counter == HOLD_TIME-1 and no pulse pending SHALL pulse done on the next cycle and enter IDLE.
REQ-021 HOLD with counter == HOLD_TIME-1 and a pulse pending SHALL invert pin on the next cycle, clear the counter and pulse_pending, and enter RETURN.
REQ-022 RETURN with counter == HOLD_TIME-1 SHALL pulse done on the next cycle and enter IDLE.
REQ-023 Each pin level SHALL persist for at least HOLD_TIME cycles after any change; a level change is 1 cycle after acceptance.
REQ-024 A new request SHALL be accepted no earlier than the cycle after done is asserted.
REQ-025 The edge pulses SHALL be derived from the registered pin, so at most one edge pulse is asserted per cycle.
REQ-026 positiveedge and negativeedge SHALL never be asserted in the same cycle.
REQ-027 With HOLD_TIME=1, a pulse request SHALL produce a pin pulse exactly 1 cycle wide.
REQ-028 req_valid held high while req_ready is 0 SHALL have no effect, and the request SHALL be accepted on the first IDLE cycle.

Reset
REQ-029 Asserting reset_n low SHALL immediately force: state=IDLE, counter=0, pulse_pending=0, pin=0, positiveedge=0, negativeedge=0, done=0.
REQ-030 While reset_n is low, req_ready SHALL be 1.
REQ-031 Reset asserted mid-HOLD or mid-RETURN SHALL abort the request with no done pulse.
REQ-032 If pin was 1 when reset asserts, the fall of pin to 0 caused by reset SHALL NOT generate a negativeedge pulse.
REQ-033 Operation SHALL resume on the first rising clk edge after reset_n deasserts.

Structure
REQ-034 A shared package output_conditioner_pkg SHALL hold the state encoding (IDLE, HOLD, RETURN) and the default COUNTER_WIDTH/HOLD_TIME constants.
REQ-035 One sub-module, hold_timer (clear, enable, terminal-count flag, parameterised width and limit), SHALL implement the counter.
REQ-036 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs other than req_ready from state.

Verification
REQ-037 Reset, then idle 20 cycles -> pin=0, req_ready=1, no edge or done pulses.
REQ-038 Level request req_level=1 -> pin=1 one cycle later with positiveedge; req_ready=0 for 14 cycles; done 14 cycles after the pin change.
REQ-039 Pulse request from pin=0 -> pin high exactly 14 cycles (positiveedge), then low for 14 cycles (negativeedge), then done; total 28 cycles busy.
REQ-040 Level request equal to current pin -> no edge pulse, done on next cycle, req_ready stays 1.
REQ-041 req_valid held high continuously with alternating req_level -> pin toggles every 15 cycles, and every high/low dwell is >=14 cycles.
REQ-042 Reset mid-HOLD with pin=1 -> pin=0 at once, no done, no negativeedge, req_ready=1.
REQ-043 Loopback of pin into the existing input conditioner (waittime 10) -> every pulse request yields exactly one rising and one falling event there.
